inst_queue: RTL

- Circular instruction buffer between fetch and decode.
- Fetch writes one 16-bit instruction plus its PC per cycle. Decode reads the head entry first-word-fall-through.
- opco_out and jmp_off_out drive the control unit's opco_in and jmp_off_in directly.
- When the queue is empty, all instruction outputs are zero. The control unit then decodes a NOP (opcode 0000, inst_vld=0).

---
 rtl/inst_queue.sv | 77 +++++++
 1 files changed

// File: rtl/inst_queue.sv
// inst_queue: circular instruction buffer between fetch and decode.
// Fetch pushes {pc, inst} pairs. Decode sees the head entry first-word-fall-through.
// When the queue is empty every instruction output is zero, so decode receives a NOP.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_in,
    input  logic             wr_vld_in,
    input  logic [15:0]      inst_in,
    input  logic [15:0]      pc_in,
    input  logic             rd_en_in,
    output logic [15:0]      inst_out,
    output logic [15:0]      pc_out,
    output logic [3:0]       opco_out,
    output logic [1:0]       jmp_off_out,
    output logic             vld_out,
    output logic             full_out,
    output logic [PTR_W:0]   count_out
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Each entry is {pc, inst}. Storage is not reset because its contents are don't-care.
    logic [31:0]      mem [DEPTH];
    // The MSB of each pointer is a wrap bit. It tells a full queue apart from an empty one.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic [31:0]      head;

    // Status flags and the push/pop qualification. Flush discards both operations.
    // While full, a push is accepted only if a pop frees a slot in the same cycle.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        do_pop  = rd_en_in && !empty && !flush_in;
        do_push = wr_vld_in && !flush_in && (!full || do_pop);
    end

    // Pointer update. Reset takes priority, and flush is the next highest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_in) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Write the accepted entry into the slot selected by the low bits of the write pointer.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr[PTR_W-1:0]] <= {pc_in, inst_in};
    end

    // Head outputs depend only on registered state. They are forced to zero while the queue is empty.
    always_comb begin
        head        = empty ? 32'h0 : mem[rd_ptr[PTR_W-1:0]];
        inst_out    = head[15:0];
        pc_out      = head[31:16];
        opco_out    = head[15:12];
        jmp_off_out = head[1:0];
        vld_out     = !empty;
        full_out    = full;
        count_out   = wr_ptr - rd_ptr;
    end

endmodule
